// File: rtl/pcm_dcblock_fifo.sv
// DC-blocking output stage for the FIR decimator: a leaky-integrator high-pass
// feeds a show-ahead FIFO with a valid/ready read port and drop accounting.
module pcm_dcblock_fifo #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DC_SHIFT = 10,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     PushIn,
    input  logic [DATA_W-1:0]        DinIn,
    input  logic                     Bypass,
    input  logic                     OutReady,
    output logic                     OutValid,
    output logic [DATA_W-1:0]        OutData,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Overflow,
    output logic [DROP_W-1:0]        DropCount,
    input  logic                     ClearOvf
);

    localparam int unsigned ACC_W = DATA_W + DC_SHIFT + 1;
    localparam int unsigned D_W   = DATA_W + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic                     s1_valid;
    logic signed [D_W-1:0]    s1_y;

    logic signed [D_W-1:0]    x_ext;
    logic signed [D_W-1:0]    dc;
    logic signed [D_W-1:0]    d;
    logic signed [ACC_W-1:0]  acc_prime;
    logic signed [ACC_W-1:0]  acc_add;

    // dc = acc >>> DC_SHIFT, truncated to the difference width (upper bits of acc)
    assign x_ext     = {DinIn[DATA_W-1], DinIn};
    assign dc        = acc[DC_SHIFT +: D_W];
    assign d         = x_ext - dc;
    assign acc_prime = {DinIn[DATA_W-1], DinIn, {DC_SHIFT{1'b0}}};
    assign acc_add   = acc + {{(ACC_W-D_W){d[D_W-1]}}, d};

    // Stage 1: integrator update and pre-saturation result select
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= PRIME;
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_y     <= '0;
        end else begin
            s1_valid <= PushIn;
            if (PushIn) begin
                case (state)
                    PRIME: begin
                        acc   <= acc_prime;
                        s1_y  <= Bypass ? x_ext : '0;
                        state <= RUN;
                    end
                    RUN: begin
                        if (Bypass) begin
                            s1_y <= x_ext;
                        end else begin
                            acc  <= acc_add;
                            s1_y <= d;
                        end
                    end
                    default: state <= PRIME;
                endcase
            end
        end
    end

    // Stage 2: saturate to the sample range
    logic [DATA_W-1:0] y_sat;
    always_comb begin
        y_sat = s1_y[DATA_W-1:0];
        if (s1_y[D_W-1] != s1_y[D_W-2]) begin
            y_sat = s1_y[D_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              pop;
    logic              full;
    logic              wr;
    logic              drop;
    logic [LVL_W-1:0]  level_n;
    logic [PTR_W-1:0]  rd_n;
    logic [DATA_W-1:0] head_n;
    logic [DROP_W-1:0] drop_inc;

    assign pop      = OutValid & OutReady;
    assign full     = (Level == LVL_W'(DEPTH));
    assign wr       = s1_valid & (~full | pop);
    assign drop     = s1_valid & full & ~pop;
    assign level_n  = Level + LVL_W'(wr) - LVL_W'(pop);
    assign rd_n     = rd_ptr + PTR_W'(pop);
    assign drop_inc = (DropCount == {DROP_W{1'b1}}) ? DropCount : DropCount + DROP_W'(1);

    // Next head: the incoming sample when it lands in an otherwise empty FIFO
    always_comb begin
        head_n = mem[rd_n];
        if (wr && (rd_n == wr_ptr)) begin
            head_n = y_sat;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr) begin
            mem[wr_ptr] <= y_sat;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Level     <= '0;
            OutValid  <= 1'b0;
            OutData   <= '0;
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_n;
            Level    <= level_n;
            OutValid <= (level_n != '0);
            if (level_n != '0) begin
                OutData <= head_n;
            end
            // A drop in the same cycle as a clear restarts the count at one
            if (drop) begin
                Overflow  <= 1'b1;
                DropCount <= ClearOvf ? DROP_W'(1) : drop_inc;
            end else if (ClearOvf) begin
                Overflow  <= 1'b0;
                DropCount <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pcm_dcblock_fifo.sv
// Directed bench for pcm_dcblock_fifo: vector table for the filter path plus
// hand-written sequences for reset, overflow, drain and drop-counter corners.
module tb_pcm_dcblock_fifo;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        PushIn;
    logic [15:0] DinIn;
    logic        Bypass;
    logic        OutReady;
    logic        OutValid;
    logic [15:0] OutData;
    logic [4:0]  Level;
    logic        Overflow;
    logic [7:0]  DropCount;
    logic        ClearOvf;

    int checks = 0;
    int errors = 0;

    pcm_dcblock_fifo dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .PushIn    (PushIn),
        .DinIn     (DinIn),
        .Bypass    (Bypass),
        .OutReady  (OutReady),
        .OutValid  (OutValid),
        .OutData   (OutData),
        .Level     (Level),
        .Overflow  (Overflow),
        .DropCount (DropCount),
        .ClearOvf  (ClearOvf)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit rst;
        bit push;
        int din;
        bit byp;
        bit rdy;
        bit clr;
        bit ev;
        int ed;
        int el;
        bit eo;
        int edc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(bit rst, bit push, int din, bit byp, bit rdy, bit clr,
                                    bit ev, int ed, int el, bit eo, int edc);
        vecs.push_back('{rst, push, din, byp, rdy, clr, ev, ed, el, eo, edc});
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        PushIn   = 1'b0;
        Bypass   = 1'b0;
        ClearOvf = 1'b0;
        Reset    = 1'b1;
        #2;
        Reset    = 1'b0;
    endtask

    task automatic chk_status(string tag, int ev, int el, int eo, int edc);
        chk({tag, ".valid"}, int'(OutValid), ev);
        chk({tag, ".level"}, int'(Level), el);
        chk({tag, ".ovf"}, int'(Overflow), eo);
        chk({tag, ".drops"}, int'(DropCount), edc);
    endtask

    initial begin
        Reset    = 1'b1;
        PushIn   = 1'b0;
        DinIn    = '0;
        Bypass   = 1'b0;
        OutReady = 1'b0;
        ClearOvf = 1'b0;
        #1;
        chk_status("por", 0, 0, 0, 0);
        chk("por.data", int'($signed(OutData)), 0);
        #2;
        Reset = 1'b0;
        step();

        // DC removal with K=10
        add_vec(1, 1, 1000, 0, 1, 0,  0,      0, 0, 0, 0);
        add_vec(0, 1, 1000, 0, 1, 0,  1,      0, 1, 0, 0);
        add_vec(0, 1, 2024, 0, 1, 0,  1,      0, 1, 0, 0);
        add_vec(0, 1, 2024, 0, 1, 0,  1,   1024, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  1,   1023, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  0,      0, 0, 0, 0);
        // Saturation after priming at full scale
        add_vec(1, 1, 32767, 0, 1, 0, 0,      0, 0, 0, 0);
        add_vec(0, 1, -32768, 0, 1, 0, 1,     0, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  1, -32768, 1, 0, 0);
        // Bypass keeps acc frozen: acc = 32767*1024 - 65535, dc = 32703
        add_vec(0, 1, -32768, 1, 1, 0, 0,     0, 0, 0, 0);
        add_vec(0, 1,    5, 1, 1, 0,  1, -32768, 1, 0, 0);
        add_vec(0, 1, 32767, 1, 1, 0, 1,      5, 1, 0, 0);
        add_vec(0, 1, 32703, 0, 1, 0, 1,  32767, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  1,      0, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  0,      0, 0, 0, 0);
        // Bypass during prime still loads acc
        add_vec(1, 1,    7, 1, 1, 0,  0,      0, 0, 0, 0);
        add_vec(0, 1,    7, 0, 1, 0,  1,      7, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  1,      0, 1, 0, 0);
        add_vec(0, 0,    0, 0, 1, 0,  0,      0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            PushIn   = vecs[i].push;
            DinIn    = 16'(vecs[i].din);
            Bypass   = vecs[i].byp;
            OutReady = vecs[i].rdy;
            ClearOvf = vecs[i].clr;
            step();
            chk_status($sformatf("vec%0d", i), int'(vecs[i].ev), vecs[i].el,
                       int'(vecs[i].eo), vecs[i].edc);
            if (vecs[i].ev)
                chk($sformatf("vec%0d.data", i), int'($signed(OutData)), vecs[i].ed);
        end
        PushIn = 1'b0;

        // Reset mid-burst, then the next push must prime
        do_reset();
        OutReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            PushIn = 1'b1;
            DinIn  = 16'(1000 + i * 100);
            step();
        end
        chk_status("burst", 1, 16, 1, 3);
        #2;
        Reset = 1'b1;
        #1;
        chk_status("midrst", 0, 0, 0, 0);
        PushIn = 1'b0;
        step();
        Reset = 1'b0;
        OutReady = 1'b1;
        PushIn = 1'b1;
        DinIn  = 16'(500);
        step();
        chk("reprime.v0", int'(OutValid), 0);
        PushIn = 1'b0;
        step();
        chk("reprime.valid", int'(OutValid), 1);
        chk("reprime.data", int'($signed(OutData)), 0);
        step();

        // Overflow with 20 pushes, then in-order drain
        do_reset();
        OutReady = 1'b0;
        Bypass   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            PushIn = 1'b1;
            DinIn  = 16'(i + 1);
            step();
        end
        PushIn = 1'b0;
        step();
        step();
        chk_status("ovf", 1, 16, 1, 4);
        chk("ovf.head", int'($signed(OutData)), 1);
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.valid", i), int'(OutValid), 1);
            chk($sformatf("drain%0d.data", i), int'($signed(OutData)), i + 1);
            step();
        end
        chk("drained.valid", int'(OutValid), 0);
        chk("drained.level", int'(Level), 0);
        step();
        chk("idle_ready.level", int'(Level), 0);

        // Full with simultaneous write and pop
        do_reset();
        OutReady = 1'b0;
        Bypass   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            PushIn = 1'b1;
            DinIn  = 16'(i + 1);
            step();
        end
        PushIn = 1'b0;
        step();
        chk_status("full", 1, 16, 0, 0);
        PushIn = 1'b1;
        DinIn  = 16'(100);
        step();
        PushIn   = 1'b0;
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk_status("wrpop", 1, 16, 0, 0);
        chk("wrpop.head", int'($signed(OutData)), 2);

        // Single drop, then drop coincident with clear, then clear alone
        PushIn = 1'b1;
        DinIn  = 16'(200);
        step();
        PushIn = 1'b0;
        step();
        chk_status("drop1", 1, 16, 1, 1);
        PushIn = 1'b1;
        step();
        PushIn   = 1'b0;
        ClearOvf = 1'b1;
        step();
        ClearOvf = 1'b0;
        chk_status("clrdrop", 1, 16, 1, 1);
        ClearOvf = 1'b1;
        step();
        ClearOvf = 1'b0;
        chk_status("clr", 1, 16, 0, 0);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) begin
            PushIn = 1'b1;
            DinIn  = 16'(i);
            step();
        end
        PushIn = 1'b0;
        step();
        chk_status("sat", 1, 16, 1, 255);
        chk("sat.head", int'($signed(OutData)), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
